// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
// Holds FSM encoding, default sizing and the MIPS load/store opcodes.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_LATENCY     = 2;
    localparam int DEF_DEPTH_BYTES = 1024;
    localparam int DEF_CNT_W       = 4;

    localparam logic [5:0] OP_LW = 6'd35;
    localparam logic [5:0] OP_SW = 6'd43;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/acknowledge bus between the pipeline MEM stage and the
// data-memory responder.
interface dmem_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, busy
    );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with a 32-bit little-endian word port.
// Contents are deliberately not reset so they survive a pipeline reset.
module dmem_byte_array #(
    parameter  int DEPTH_BYTES = 1024,
    localparam int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [7:0]    mem_array [DEPTH_BYTES];
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;

    assign a1 = addr_i + AW'(1);
    assign a2 = addr_i + AW'(2);
    assign a3 = addr_i + AW'(3);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_array[addr_i] <= wdata_i[7:0];
            mem_array[a1]     <= wdata_i[15:8];
            mem_array[a2]     <= wdata_i[23:16];
            mem_array[a3]     <= wdata_i[31:24];
        end
    end

    assign rdata_o = {mem_array[a3], mem_array[a2],
                      mem_array[a1], mem_array[addr_i]};

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle LW/SW responder: latches a request, waits LATENCY edges,
// then performs the access and pulses ack (with err for bad addresses).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    dmem_if.slave bus
);

    localparam int              AW        = $clog2(DEPTH_BYTES);
    localparam logic [31:0]     LAST_WORD = 32'(DEPTH_BYTES - 4);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             access;
    logic             bad_addr;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    // Full 32-bit compare: high address bits must never alias into the array.
    assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q > LAST_WORD);
    assign access   = (state_q == WAIT) && (cnt_q == '0);
    // Gating with rst keeps a reset on the access edge from committing a store.
    assign mem_we   = access && we_q && !bad_addr && !rst;

    dmem_byte_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_arr (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ack_d   = 1'b1;
                    err_d   = bad_addr;
                    state_d = RESP;
                    if (bad_addr) begin
                        rdata_d = 32'h0;
                    end else if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == WAIT) || (state_d == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, held-request and reset
// sequences, a LATENCY=1 instance, and a randomized run against a byte model.
module tb_dmem_responder;

    localparam int LAT2  = 2;
    localparam int LAT1  = 1;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    dmem_if b1 ();
    dmem_if b2 ();

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT2), .CNT_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT1), .CNT_W(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] exp_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (s == 1) begin
            b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d;
        end else begin
            b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
        end
    endtask

    function automatic logic ack_of(input int s);
        return (s == 1) ? b1.ack : b2.ack;
    endfunction
    function automatic logic err_of(input int s);
        return (s == 1) ? b1.err : b2.err;
    endfunction
    function automatic logic busy_of(input int s);
        return (s == 1) ? b1.busy : b2.busy;
    endfunction
    function automatic logic [31:0] rd_of(input int s);
        return (s == 1) ? b1.rdata : b2.rdata;
    endfunction

    // One full transaction; request fields are scrambled after acceptance.
    task automatic xfer(input int s, input int lat, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int acc);
        int n;
        drive(s, 1'b1, w, a, d);
        @(posedge clk); #1;
        acc = cyc;
        chk("busy_after_accept", 32'(busy_of(s)), 32'd1);
        drive(s, 1'b1, ~w, a ^ 32'h4, ~d);
        n = 0;
        while (ack_of(s) !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_latency", 32'(n), 32'(lat));
        rd = rd_of(s);
        er = err_of(s);
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack_of(s)), 32'd0);
        chk("err_one_cycle", 32'(err_of(s)), 32'd0);
        chk("busy_back_idle", 32'(busy_of(s)), 32'd0);
    endtask

    vec_t        tbl [14];
    logic [31:0] rd;
    logic        er;
    int          acc;
    int          acc_sw8;
    logic [31:0] held_addr [3];
    logic [31:0] held_val  [3];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 32'd0,        32'h12345678, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 32'd0,        32'h0,        32'h12345678, 1'b0};
        tbl[2]  = '{1'b1, 32'd8,        32'hDEADBEEF, 32'h12345678, 1'b0};
        tbl[3]  = '{1'b0, 32'd8,        32'h0,        32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b0, 32'd6,        32'h0,        32'h00000000, 1'b1};
        tbl[5]  = '{1'b0, 32'd1024,     32'h0,        32'h00000000, 1'b1};
        tbl[6]  = '{1'b1, 32'd1024,     32'h11111111, 32'h00000000, 1'b1};
        tbl[7]  = '{1'b0, 32'd0,        32'h0,        32'h12345678, 1'b0};
        tbl[8]  = '{1'b1, 32'd1020,     32'hA5B6C7D8, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b0, 32'd1020,     32'h0,        32'hA5B6C7D8, 1'b0};
        tbl[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1};
        tbl[11] = '{1'b1, 32'd16,       32'h11223344, 32'h00000000, 1'b0};
        tbl[12] = '{1'b1, 32'd9,        32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[13] = '{1'b0, 32'd8,        32'h0,        32'hDEADBEEF, 1'b0};

        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack",   32'(b2.ack),  32'd0);
        chk("reset_err",   32'(b2.err),  32'd0);
        chk("reset_busy",  32'(b2.busy), 32'd0);
        chk("reset_rdata", b2.rdata,     32'h0);
        chk("reset_rdata1", b1.rdata,    32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_req_busy", 32'(b2.busy), 32'd0);

        // Directed table on the LATENCY=2 instance.
        acc_sw8 = 0;
        for (int i = 0; i < 14; i++) begin
            xfer(2, LAT2, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, acc);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            if (i == 2) acc_sw8 = acc;
            if (i == 3) chk("accept_spacing", 32'(acc - acc_sw8), 32'(LAT2 + 2));
        end
        chk("byte8",  32'(dut2.u_arr.mem_array[8]),  32'hEF);
        chk("byte9",  32'(dut2.u_arr.mem_array[9]),  32'hBE);
        chk("byte10", 32'(dut2.u_arr.mem_array[10]), 32'hAD);
        chk("byte11", 32'(dut2.u_arr.mem_array[11]), 32'hDE);

        // Continuously held req: one ack every LAT2+2 edges.
        held_addr[0] = 32'd0;    held_val[0] = 32'h12345678;
        held_addr[1] = 32'd8;    held_val[1] = 32'hDEADBEEF;
        held_addr[2] = 32'd1020; held_val[2] = 32'hA5B6C7D8;
        begin
            int idx;
            idx = 0;
            drive(2, 1'b1, 1'b0, held_addr[0], 32'h0);
            for (int k = 0; k < 3 * (LAT2 + 2); k++) begin
                @(posedge clk); #1;
                chk("held_ack", 32'(b2.ack),
                    32'((k % (LAT2 + 2)) == LAT2));
                if (b2.ack === 1'b1) begin
                    if (idx < 3) chk("held_rdata", b2.rdata, held_val[idx]);
                    idx++;
                    if (idx < 3) b2.addr = held_addr[idx];
                end
            end
            drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("held_count", 32'(idx), 32'd3);
            @(posedge clk); #1;
            chk("held_after_busy", 32'(b2.busy), 32'd0);
        end

        // Reset during WAIT cancels the pending store.
        drive(2, 1'b1, 1'b1, 32'd16, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_busy",  32'(b2.busy), 32'd0);
        chk("rst_ack",   32'(b2.ack),  32'd0);
        chk("rst_rdata", b2.rdata,     32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_ack_after", 32'(b2.ack), 32'd0);
        xfer(2, LAT2, 1'b0, 32'd16, 32'h0, rd, er, acc);
        chk("rst_no_write", rd, 32'h11223344);
        chk("rst_no_write_err", 32'(er), 32'd0);
        exp_rd = 32'h11223344;

        // LATENCY=1 instance; scrambled addr during WAIT points at word 0.
        xfer(1, LAT1, 1'b1, 32'd4, 32'h00000001, rd, er, acc);
        chk("l1_sw4_rdata", rd, 32'h0);
        xfer(1, LAT1, 1'b1, 32'd0, 32'hBBBBBBBB, rd, er, acc);
        chk("l1_sw0_rdata", rd, 32'h0);
        xfer(1, LAT1, 1'b0, 32'd4, 32'h0, rd, er, acc);
        chk("l1_lw4_rdata", rd, 32'h00000001);
        chk("l1_lw4_err", 32'(er), 32'd0);

        // Randomized run over a 64-byte window plus bad addresses.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            int ia;
            d = $urandom;
            ia = 64 + 4 * w;
            xfer(2, LAT2, 1'b1, 32'(ia), d, rd, er, acc);
            chk("fill_rdata_hold", rd, exp_rd);
            chk("fill_err", 32'(er), 32'd0);
            for (int b = 0; b < 4; b++) ref_mem[ia + b] = d[8*b +: 8];
        end
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            logic        bad;
            int          mode;
            mode = $urandom_range(0, 5);
            w    = 1'($urandom_range(0, 1));
            d    = $urandom;
            if (mode == 0)
                a = 32'(64 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (mode == 1)
                a = 32'(DEPTH + 4 * $urandom_range(0, 63));
            else if (mode == 2)
                a = {1'b1, 29'($urandom), 2'b00};
            else
                a = 32'(64 + 4 * $urandom_range(0, 15));
            bad = (a % 4 != 0) || (a > 32'(DEPTH - 4));
            if (bad) begin
                exp_rd = 32'h0;
            end else if (w) begin
                for (int b = 0; b < 4; b++) ref_mem[int'(a) + b] = d[8*b +: 8];
            end else begin
                exp_rd = 32'h0;
                for (int b = 0; b < 4; b++)
                    exp_rd = exp_rd + (32'(ref_mem[int'(a) + b]) << (8 * b));
            end
            xfer(2, LAT2, w, a, d, rd, er, acc);
            chk($sformatf("rand%0d_rdata a=%h", t, a), rd, exp_rd);
            chk($sformatf("rand%0d_err a=%h", t, a), 32'(er), 32'(bad));
        end
        for (int w = 0; w < 16; w++) begin
            int ia;
            ia = 64 + 4 * w;
            exp_rd = {ref_mem[ia + 3], ref_mem[ia + 2],
                      ref_mem[ia + 1], ref_mem[ia]};
            xfer(2, LAT2, 1'b0, 32'(ia), 32'h0, rd, er, acc);
            chk($sformatf("final_word%0d", w), rd, exp_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
